// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    // A nibble at or above 8 after a right shift came from a tens-weight bit
    // landing in a units-weight position; subtracting 3 (= 16/2 - 10/2)
    // restores the decimal weighting.
    localparam bcd_digit_t BCD_CORR_THRESH = 4'd8;
    localparam bcd_digit_t BCD_CORR_SUB    = 4'd3;
    localparam bcd_digit_t BCD_MAX_DIGIT   = 4'd9;

    // True when the nibble is a legal decimal digit.
    function automatic logic bcd_digit_ok(input bcd_digit_t d);
        return (d <= BCD_MAX_DIGIT);
    endfunction

endpackage

// File: rtl/bcd_digit_corr.sv
// Per-nibble correction of reverse double-dabble: d >= 8 ? d - 3 : d.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of its input.
module bcd_digit_corr
    import bcd_pkg::*;
(
    input  bcd_digit_t d,
    output bcd_digit_t q
);

    // Unsigned nibble subtract; no borrow leaves this digit.
    assign q = (d >= BCD_CORR_THRESH) ? bcd_digit_t'(d - BCD_CORR_SUB) : d;

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter (reverse double-dabble, one bit per clock); optional BCD_CHECK_EN adds invalid-digit flagging on err.
// Latency: start accepted at edge k, done/bin_out after edge k+BIN_W (BIN_W+1 edges counting the accept edge); one conversion per BIN_W+2 cycles.
// Backpressure: start is only sampled in IDLE; starts while busy are dropped, not queued.
module bcd_to_bin
    import bcd_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err
);

    localparam int SR_W  = 4*DIGITS + BIN_W;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    // The largest DIGITS-digit decimal value must fit the binary result.
    generate
        if ((10**DIGITS) - 1 > (2**BIN_W) - 1) begin : g_width_chk
            $error("bcd_to_bin: BIN_W too narrow for DIGITS");
        end
    endgenerate

    state_t            state;
    logic [SR_W-1:0]   sr;
    logic [SR_W-1:0]   sr_shift;
    logic [SR_W-1:0]   sr_next;
    logic [CNT_W-1:0]  cnt;

    // BCD digits sit above the binary field; the shift moves the BCD LSB
    // into the binary field, which fills from the top downwards.
    assign sr_shift = sr >> 1;
    assign sr_next[BIN_W-1:0] = sr_shift[BIN_W-1:0];

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_corr
            bcd_digit_corr u_corr (
                .d (sr_shift[BIN_W + 4*g +: 4]),
                .q (sr_next[BIN_W + 4*g +: 4])
            );
        end
    endgenerate

    // Control FSM with shift register, bit counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            bin_out <= '0;
            sr      <= '0;
            cnt     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SHIFT;
                        busy  <= 1'b1;
                        sr    <= {bcd_in, {BIN_W{1'b0}}};
                        cnt   <= CNT_W'(BIN_W - 1);
                    end
                end
                SHIFT: begin
                    sr <= sr_next;
                    if (cnt == '0) begin
                        state   <= DONE;
                        bin_out <= sr_next[BIN_W-1:0];
                        done    <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef BCD_CHECK_EN
    logic bad_digit;
    logic bad_flag;

    // Any non-decimal nibble in the operand presented this cycle.
    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!bcd_digit_ok(bcd_in[4*i +: 4])) begin
                bad_digit = 1'b1;
            end
        end
    end

    // Latch the operand check at accept, publish it alongside done.
    always_ff @(posedge clk) begin
        if (rst) begin
            bad_flag <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                bad_flag <= bad_digit;
            end
            if (state == SHIFT && cnt == '0) begin
                err <= bad_flag;
            end
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin against a decimal-arithmetic reference.
// Latency: n/a.
// Backpressure: n/a.
module tb_bcd_to_bin;

    localparam int DIGITS = 3;
    localparam int BIN_W  = 10;

    logic              clk;
    logic              rst;
    logic              start;
    logic [11:0]       bcd_in;
    logic              busy;
    logic              done;
    logic [BIN_W-1:0]  bin_out;
    logic              err;

    int n_checks = 0;
    int n_errors = 0;

    bcd_to_bin #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bcd_in  (bcd_in),
        .busy    (busy),
        .done    (done),
        .bin_out (bin_out),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: weighted sum of decimal digits.
    function automatic int bcd_value(input logic [11:0] b);
        return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [11:0] rand_bcd();
        logic [11:0] b;
        b[11:8] = 4'($urandom_range(0, 9));
        b[7:4]  = 4'($urandom_range(0, 9));
        b[3:0]  = 4'($urandom_range(0, 9));
        return b;
    endfunction

    // One conversion: pulse start, optionally retry start mid-flight,
    // then measure latency and check the result.
    task automatic convert(input string tag, input logic [11:0] b, input bit chk_val,
                           input int exp_err, input int retry_at);
        int edges;
        @(negedge clk);
        start  = 1'b1;
        bcd_in = b;
        @(negedge clk);
        edges  = 1;
        start  = 1'b0;
        bcd_in = 12'($urandom);
        check({tag, "_busy"}, int'(busy), 1);
        while (!done && edges < 40) begin
            if (edges == retry_at) begin
                start  = 1'b1;
                bcd_in = 12'h456;
            end
            @(negedge clk);
            start = 1'b0;
            edges++;
        end
        check({tag, "_latency"}, edges, 11);
        if (chk_val) check({tag, "_value"}, int'(bin_out), bcd_value(b));
        check({tag, "_err"}, int'(err), exp_err);
        @(negedge clk);
        check({tag, "_done_pulse"}, int'(done), 0);
    endtask

    initial begin
        int dones;
        int t;
        int last_t;
        int vals[3];
        logic [11:0] b;

        rst    = 1'b1;
        start  = 1'b0;
        bcd_in = 12'h000;
        repeat (2) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_bin", int'(bin_out), 0);
        check("rst_err", int'(err), 0);
        rst = 1'b0;

        // Directed corner values.
        convert("d999", 12'h999, 1'b1, 0, -1);
        convert("d000", 12'h000, 1'b1, 0, -1);
        convert("d512", 12'h512, 1'b1, 0, -1);
        convert("d009", 12'h009, 1'b1, 0, -1);

        // Start during a conversion must be ignored.
        convert("ign123", 12'h123, 1'b1, 0, 3);
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("ign_extra_done", dones, 0);
        check("ign_hold_val", int'(bin_out), 123);

        // Random valid operands.
        for (int i = 0; i < 20; i++) begin
            b = rand_bcd();
            convert("rand", b, 1'b1, 0, -1);
        end

        // Reset mid-conversion discards everything.
        convert("pre_rst", 12'h777, 1'b1, 0, -1);
        @(negedge clk);
        start  = 1'b1;
        bcd_in = 12'h321;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_done", int'(done), 0);
        check("mid_rst_bin", int'(bin_out), 0);
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("mid_rst_no_done", dones, 0);

        // Start held high: back-to-back conversions every BIN_W+2 cycles.
        @(negedge clk);
        start  = 1'b1;
        bcd_in = 12'h250;
        @(negedge clk);
        bcd_in = 12'h001;
        t      = 1;
        dones  = 0;
        last_t = 0;
        while (dones < 3 && t < 60) begin
            if (done) begin
                if (dones == 0) check("b2b_first_lat", t, 11);
                else            check("b2b_period", t - last_t, 12);
                vals[dones] = int'(bin_out);
                last_t = t;
                dones++;
            end
            @(negedge clk);
            t++;
        end
        start = 1'b0;
        check("b2b_count", dones, 3);
        check("b2b_val0", vals[0], 250);
        check("b2b_val1", vals[1], 1);
        t = 0;
        while (busy && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("b2b_drain", int'(busy), 0);

`ifdef BCD_CHECK_EN
        convert("bad1A3", 12'h1A3, 1'b0, 1, -1);
        convert("ok100", 12'h100, 1'b1, 0, -1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
